// File: rtl/shape_processor_ctrl_bank.sv
// Bank of per-channel shape/operation CTRL registers with legality checks.
// Ports: clk, rst_n (sync, active-low), write/write_addr/write_data,
//   read/read_addr, read_data (combinational).
// Map: 0..N-1 CTRL[ch], N ERR_STATUS (W1C), N+1 REJECT_CNT.
// Optional macro SHAPE_PROCESSOR_REJECT_CNT_EN adds the 8-bit
//   saturating reject counter; otherwise address N+1 reads 0.
module shape_processor_ctrl_bank #(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_W = $clog2(NUM_CHANNELS + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [31:0]       write_data,
  input  logic              read,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [31:0]       read_data
);

  localparam logic [ADDR_W-1:0] ERR_ADDR = ADDR_W'(NUM_CHANNELS);
  localparam logic [ADDR_W-1:0] CNT_ADDR = ADDR_W'(NUM_CHANNELS + 1);

  localparam logic [2:0] SH_CIRCLE = 3'd0;
  localparam logic [2:0] SH_RECT   = 3'd1;
  localparam logic [2:0] SH_TRI    = 3'd2;
  localparam logic [2:0] SH_KEEP   = 3'd7;

  localparam logic [2:0] OP_PERIM  = 3'd0;
  localparam logic [2:0] OP_AREA   = 3'd1;
  localparam logic [2:0] OP_SQUARE = 3'd2;
  localparam logic [2:0] OP_EQUI   = 3'd3;
  localparam logic [2:0] OP_ISO    = 3'd4;
  localparam logic [2:0] OP_KEEP   = 3'd7;

  logic [NUM_CHANNELS-1:0][2:0] shape_q, shape_d;
  logic [NUM_CHANNELS-1:0][2:0] op_q, op_d;
  logic [NUM_CHANNELS-1:0]      err_q, err_d;

  logic [2:0] cur_shape, cur_op;
  logic [2:0] new_shape, new_op;
  logic [2:0] eff_shape, eff_op;
  logic       wr_ctrl, wr_err;
  logic       rsvd, legal;
  logic       accept, reject;
  logic [31:0] cnt_rd;

  always_comb begin : decode
    wr_ctrl   = 1'b0;
    cur_shape = SH_CIRCLE;
    cur_op    = OP_AREA;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (write_addr == ADDR_W'(i)) begin
        wr_ctrl   = write;
        cur_shape = shape_q[i];
        cur_op    = op_q[i];
      end
    end
    wr_err    = write && (write_addr == ERR_ADDR);
    new_shape = write_data[2:0];
    new_op    = write_data[10:8];
    // KEEP fields inherit the stored value, so the stored pair
    // (always legal) makes KEEP/KEEP a legal no-op.
    eff_shape = (new_shape == SH_KEEP) ? cur_shape : new_shape;
    eff_op    = (new_op == OP_KEEP) ? cur_op : new_op;
    rsvd = (new_shape inside {[3'd3:3'd6]}) ||
           (new_op inside {3'd5, 3'd6});
    case (eff_op)
      OP_PERIM, OP_AREA: legal = 1'b1;
      OP_SQUARE:         legal = (eff_shape == SH_RECT);
      OP_EQUI, OP_ISO:   legal = (eff_shape == SH_TRI);
      default:           legal = 1'b0;
    endcase
    accept = wr_ctrl && !rsvd && legal;
    reject = wr_ctrl && !accept;
  end

  always_comb begin : next_state
    shape_d = shape_q;
    op_d    = op_q;
    err_d   = err_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (write_addr == ADDR_W'(i)) begin
        if (accept) begin
          shape_d[i] = eff_shape;
          op_d[i]    = eff_op;
        end
        if (reject) err_d[i] = 1'b1;
      end
    end
    if (wr_err) err_d = err_q & ~write_data[NUM_CHANNELS-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        shape_q[i] <= SH_CIRCLE;
        op_q[i]    <= OP_AREA;
      end
      err_q <= '0;
    end else begin
      shape_q <= shape_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

`ifdef SHAPE_PROCESSOR_REJECT_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin : cnt_next
    cnt_d = cnt_q;
    if (wr_err && (write_data != '0)) cnt_d = '0;
    else if (reject && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_rd = {24'b0, cnt_q};
`else
  logic unused_wdata;
  assign unused_wdata = ^{write_data[31:11], write_data[7:3]};
  assign cnt_rd = '0;
`endif

  always_comb begin : read_mux
    read_data = '0;
    if (read) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (read_addr == ADDR_W'(i))
          read_data = {21'b0, op_q[i], 5'b0, shape_q[i]};
      end
      if (read_addr == ERR_ADDR) read_data = 32'(err_q);
      if (read_addr == CNT_ADDR) read_data = cnt_rd;
    end
  end

endmodule

// File: tb/tb_shape_processor_ctrl_bank.sv
// Directed-vector bench for shape_processor_ctrl_bank (NUM_CHANNELS=4).
// Expected values are hand-computed constants.
module tb_shape_processor_ctrl_bank;

  localparam int N = 4;
  localparam int AW = 3;
  localparam logic [AW-1:0] ERR = 3'd4;
  localparam logic [AW-1:0] CNT = 3'd5;
`ifdef SHAPE_PROCESSOR_REJECT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          write;
  logic [AW-1:0] write_addr;
  logic [31:0]   write_data;
  logic          read;
  logic [AW-1:0] read_addr;
  logic [31:0]   read_data;

  int n_chk = 0;
  int n_pass = 0;

  shape_processor_ctrl_bank #(.NUM_CHANNELS(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write      (write),
    .write_addr (write_addr),
    .write_data (write_data),
    .read       (read),
    .read_addr  (read_addr),
    .read_data  (read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
    return CNT_EN ? v : 32'h0;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    write      = 1'b1;
    write_addr = a;
    write_data = d;
    @(negedge clk);
    write      = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [AW-1:0] a,
                    input logic [31:0] exp);
    read      = 1'b1;
    read_addr = a;
    #1;
    chk(tag, read_data, exp);
    read      = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    write      = 1'b0;
    write_addr = '0;
    write_data = '0;
    read       = 1'b0;
    read_addr  = 3'd2;
    repeat (3) @(negedge clk);
    #1;
    chk("rd_low_in_reset", read_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    rd("rst_ctrl2", 3'd2, 32'h100);
    rd("rst_ctrl0", 3'd0, 32'h100);
    rd("rst_err", ERR, 32'h0);
    rd("rst_cnt", CNT, 32'h0);
    rd("unmapped6", 3'd6, 32'h0);
    rd("unmapped7", 3'd7, 32'h0);

    wr(3'd1, 32'h201);
    rd("rect_square", 3'd1, 32'h201);
    rd("ch0_untouched", 3'd0, 32'h100);

    wr(3'd1, 32'h702);
    rd("tri_keep_rej", 3'd1, 32'h201);
    rd("err_ch1", ERR, 32'h2);
    rd("cnt_one", CNT, cnt_exp(1));
    wr(ERR, 32'h2);
    rd("err_clr1", ERR, 32'h0);
    rd("cnt_clr1", CNT, 32'h0);

    wr(3'd0, 32'h105);
    rd("rsvd_shape", 3'd0, 32'h100);
    rd("err_ch0", ERR, 32'h1);
    wr(ERR, 32'h1);
    rd("err_clr0", ERR, 32'h0);
    rd("cnt_clr0", CNT, 32'h0);

    wr(3'd0, 32'h105);
    wr(3'd2, 32'h300);
    rd("circ_equi_rej", 3'd2, 32'h100);
    rd("err_ch0_ch2", ERR, 32'h5);
    rd("cnt_two", CNT, cnt_exp(2));
    wr(ERR, 32'h0);
    rd("w1c_zero_err", ERR, 32'h5);
    rd("w1c_zero_cnt", CNT, cnt_exp(2));
    wr(ERR, 32'h4);
    rd("w1c_partial", ERR, 32'h1);
    rd("cnt_partial", CNT, 32'h0);
    wr(ERR, 32'hF);

    wr(3'd3, 32'h102);
    rd("tri_area", 3'd3, 32'h102);
    @(negedge clk);
    write      = 1'b1;
    write_addr = 3'd3;
    write_data = 32'h407;
    read       = 1'b1;
    read_addr  = 3'd3;
    #1;
    chk("rd_pre_write", read_data, 32'h102);
    read = 1'b0;
    @(negedge clk);
    write = 1'b0;
    rd("keep_iso", 3'd3, 32'h402);

    wr(3'd3, 32'h707);
    rd("keep_keep", 3'd3, 32'h402);
    wr(3'd1, 32'h007);
    rd("keep_perim", 3'd1, 32'h001);
    rd("no_err", ERR, 32'h0);

    wr(CNT, 32'hFF);
    wr(3'd6, 32'h123);
    rd("ign_err", ERR, 32'h0);
    rd("ign_cnt", CNT, 32'h0);
    rd("ign_ctrl2", 3'd2, 32'h100);
    read_addr = 3'd1;
    #1;
    chk("rd_low", read_data, 32'h0);

    wr(3'd2, 32'h602);
    rd("rsvd_op", 3'd2, 32'h100);
    rd("err_ch2", ERR, 32'h4);
    wr(ERR, 32'h4);

    for (int i = 0; i < 300; i++) wr(3'd0, 32'h105);
    rd("cnt_sat", CNT, cnt_exp(255));
    rd("err_sat", ERR, 32'h1);
    rd("ctrl0_sat", 3'd0, 32'h100);

    @(negedge clk);
    rst_n      = 1'b0;
    write      = 1'b1;
    write_addr = 3'd1;
    write_data = 32'h002;
    @(negedge clk);
    write = 1'b0;
    rst_n = 1'b1;
    rd("rr_ctrl0", 3'd0, 32'h100);
    rd("rr_ctrl1", 3'd1, 32'h100);
    rd("rr_ctrl2", 3'd2, 32'h100);
    rd("rr_ctrl3", 3'd3, 32'h100);
    rd("rr_err", ERR, 32'h0);
    rd("rr_cnt", CNT, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shape_processor_ctrl_bank.md
SHAPE_PROCESSOR_CTRL_BANK -- requirements
Module: shape_processor_ctrl_bank

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of independent CTRL SFRs; legal range 1..16.
REQ-002 SHALL have derived parameter ADDR_W, default $clog2(NUM_CHANNELS+2), address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port write  input  1  bus write strobe, one access per cycle.
REQ-006 SHALL have port write_addr  input  ADDR_W  write target.
REQ-007 SHALL have port write_data  input  32  write payload.
REQ-008 SHALL have port read  input  1  bus read strobe.
REQ-009 SHALL have port read_addr  input  ADDR_W  read target.
REQ-010 SHALL have port read_data  output  32  read payload, combinational from current state.

Function
REQ-011 SHALL map addresses as follows: 0..NUM_CHANNELS-1 -> CTRL[ch]; NUM_CHANNELS -> ERR_STATUS; NUM_CHANNELS+1 -> REJECT_CNT; all others unmapped.
REQ-012 SHALL lay out CTRL as SHAPE=[2:0] and OPERATION=[10:8], with all other bits reading 0 and ignored on write.
REQ-013 SHALL encode SHAPE as 0 CIRCLE, 1 RECTANGLE, 2 TRIANGLE, 7 KEEP_SHAPE, 3..6 reserved.
REQ-014 SHALL encode OPERATION as 0 PERIMETER, 1 AREA, 2 IS_SQUARE, 3 IS_EQUILATERAL, 4 IS_ISOSCELES, 7 KEEP_OPERATION, 5..6 reserved.
REQ-015 SHALL treat as legal combinations: PERIMETER/AREA with any shape; IS_SQUARE with RECTANGLE only; IS_EQUILATERAL/IS_ISOSCELES with TRIANGLE only.
REQ-016 SHALL, for a CTRL write, form the effective pair by substituting the channel's current SHAPE for KEEP_SHAPE and its current OPERATION for KEEP_OPERATION; KEEP in both fields yields a legal no-op.
REQ-017 SHALL reject a CTRL write (channel unchanged) if either field is reserved or the effective pair is illegal.
REQ-018 SHALL load the effective pair into CTRL[ch] one cycle after an accepted write; other channels SHALL stay unchanged.
REQ-019 SHALL change CTRL[ch] only on an accepted write to address ch; never KEEP_* or reserved values, never an illegal pair.
REQ-020 SHALL keep ERR_STATUS[ch] a sticky bit, set the cycle after a rejected write to CTRL[ch]; bits >= NUM_CHANNELS read 0.
REQ-021 SHALL clear ERR_STATUS bits by write-1-to-clear to address NUM_CHANNELS; 0 bits are unaffected.
REQ-022 SHALL ignore writes to unmapped addresses and writes to REJECT_CNT; neither raises an error.
REQ-023 SHALL return 0 on read_data when read is low or read_addr is unmapped.
REQ-024 SHALL, on read and write to the same address in one cycle, return the pre-write value.
REQ-025 SHALL present write and read in the same cycle to different or same addresses without stall.

Reset
REQ-026 SHALL, while rst_n is low at a posedge, load every CTRL[ch] to SHAPE=CIRCLE, OPERATION=AREA, ERR_STATUS to 0, and REJECT_CNT to 0.
REQ-027 SHALL give reset priority over a concurrent write; the write is lost and no error is recorded.
REQ-028 SHALL drive read_data=0 while read is low, including during reset.

Configuration
REQ-029 SHALL, with macro SHAPE_PROCESSOR_REJECT_CNT_EN defined, implement REJECT_CNT as an 8-bit counter in bits [7:0] that increments by 1 on each rejected CTRL write and saturates at 255.
REQ-030 SHALL, with macro SHAPE_PROCESSOR_REJECT_CNT_EN defined, clear REJECT_CNT when any nonzero value is written to ERR_STATUS.
REQ-031 SHALL, without SHAPE_PROCESSOR_REJECT_CNT_EN, omit the counter flops and make address NUM_CHANNELS+1 read 0, behaving as unmapped.

Verification
REQ-032 SHALL cover: reset, then read addr 2 -> read_data=0x00000100 (CIRCLE/AREA).
REQ-033 SHALL cover: write addr 1 0x00000201 (RECTANGLE/IS_SQUARE) -> next-cycle read addr 1=0x00000201; addr 0 still 0x00000100.
REQ-034 SHALL cover: CTRL[1]=RECTANGLE/IS_SQUARE, write addr 1 0x00000702 (TRIANGLE/KEEP) -> CTRL[1] unchanged, ERR_STATUS=0x2, REJECT_CNT=1 when enabled.
REQ-035 SHALL cover: write addr 0 0x00000105 (reserved shape) -> CTRL[0] unchanged, ERR_STATUS bit0 set; then write ERR_STATUS 0x1 -> ERR_STATUS=0, REJECT_CNT=0.
REQ-036 SHALL cover: CTRL[3]=TRIANGLE/AREA, write addr 3 0x00000407 (KEEP/IS_ISOSCELES) -> CTRL[3]=0x00000402; simultaneous read addr 3 that cycle returns 0x00000102.
REQ-037 SHALL cover: 300 rejected writes with SHAPE_PROCESSOR_REJECT_CNT_EN defined -> REJECT_CNT=255; rst_n low concurrent with a write -> all registers at reset values.
